// File: rtl/cpu_prog_driver.sv
// Host-side initiator for the 8-bit CPU pin interface: stores a short program,
// replays it onto the CPU pins one word per cycle, and queues STB/RDS results.
module cpu_prog_driver #(
  parameter int PROG_DEPTH = 16,
  parameter int PROG_AW    = 4,
  parameter int RES_DEPTH  = 4,
  parameter int RES_AW     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load_valid,
  input  logic [15:0]        load_data,
  output logic               load_ready,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [PROG_AW:0]   prog_len,
  output logic [7:0]         cpu_ui,
  output logic [7:0]         cpu_uio,
  input  logic [7:0]         cpu_uo,
  output logic               res_valid,
  output logic [7:0]         res_data,
  input  logic               res_ready
);
  localparam int STAGES = 1;
  localparam logic [7:0]          NOP_UI  = 8'h40;
  localparam logic [PROG_AW:0]    LEN_ONE = (PROG_AW+1)'(1);
  localparam logic [PROG_AW-1:0]  PTR_ONE = PROG_AW'(1);
  localparam logic [RES_AW-1:0]   IDX_ONE = RES_AW'(1);
  localparam logic [RES_AW:0]     CNT_ONE = (RES_AW+1)'(1);
  localparam logic [RES_AW+1:0]   RES_LIM = (RES_AW+2)'(RES_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic [15:0]        prog_mem [PROG_DEPTH];
  logic [PROG_AW-1:0] rd_ptr;
  // Tag pipeline: bit 0 marks a capture word on the pins this cycle, the last
  // bit marks the cycle whose closing edge samples cpu_uo.
  logic [STAGES:0]    vld_pipe;

  logic [7:0]         res_mem [RES_DEPTH];
  logic [RES_AW-1:0]  res_wr, res_rd;
  logic [RES_AW:0]    res_cnt;

  logic [15:0]        cur_word;
  logic               cur_cap, can_issue, is_last, load_acc, push, pop;
  logic [1:0]         inflight;
  logic [RES_AW+1:0]  occupancy;
  logic [PROG_AW:0]   len_after;

  assign load_ready = (state == IDLE) && !prog_len[PROG_AW];
  assign load_acc   = load_valid && load_ready && !clear;
  assign len_after  = load_acc ? prog_len + LEN_ONE : prog_len;

  assign cur_word  = prog_mem[rd_ptr];
  assign cur_cap   = (cur_word[15:13] == 3'b001);
  assign inflight  = {1'b0, vld_pipe[0]} + {1'b0, vld_pipe[1]};
  // Reserve a FIFO slot for every capture still in flight so a push never
  // lands on a full FIFO.
  assign occupancy = {1'b0, res_cnt} + {{RES_AW{1'b0}}, inflight};
  assign can_issue = (state == RUN) && (!cur_cap || (occupancy < RES_LIM));
  assign is_last   = (({1'b0, rd_ptr} + LEN_ONE) == prog_len);

  assign push      = vld_pipe[STAGES];
  assign res_valid = (res_cnt != '0);
  assign pop       = res_ready && res_valid;
  assign res_data  = res_mem[res_rd];

  always_ff @(posedge clk) begin
    if (load_acc) prog_mem[prog_len[PROG_AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      prog_len <= '0;
      rd_ptr   <= '0;
      vld_pipe <= '0;
      cpu_ui   <= NOP_UI;
      cpu_uio  <= 8'h00;
    end else begin
      done     <= 1'b0;
      cpu_ui   <= NOP_UI;
      cpu_uio  <= 8'h00;
      vld_pipe <= {vld_pipe[STAGES-1:0], can_issue && cur_cap};
      case (state)
        IDLE: begin
          if (clear) begin
            prog_len <= '0;
          end else begin
            prog_len <= len_after;
            if (start && (len_after != '0)) begin
              state  <= RUN;
              busy   <= 1'b1;
              rd_ptr <= '0;
            end
          end
        end
        RUN: begin
          if (can_issue) begin
            cpu_ui  <= cur_word[15:8];
            cpu_uio <= cur_word[7:0];
            rd_ptr  <= rd_ptr + PTR_ONE;
            if (is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == 2'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_wr  <= '0;
      res_rd  <= '0;
      res_cnt <= '0;
      for (int i = 0; i < RES_DEPTH; i++) res_mem[i] <= 8'h00;
    end else begin
      if (push) begin
        res_mem[res_wr] <= cpu_uo;
        res_wr          <= res_wr + IDX_ONE;
      end
      if (pop) res_rd <= res_rd + IDX_ONE;
      case ({push, pop})
        2'b10:   res_cnt <= res_cnt + CNT_ONE;
        2'b01:   res_cnt <= res_cnt - CNT_ONE;
        default: res_cnt <= res_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_prog_driver.sv
// Directed bench for cpu_prog_driver: a queue-based reference model checked
// every cycle, a tiny CPU model on the pins, and literal per-scenario checks.
module tb_cpu_prog_driver;
  localparam int PD = 16, PAW = 4, RD = 4, RAW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0, load_valid = 1'b0, start = 1'b0, res_ready = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic load_ready, busy, done, res_valid;
  logic [PAW:0] prog_len;
  logic [7:0] cpu_ui, cpu_uio, cpu_uo, res_data;

  always #5 clk = ~clk;

  cpu_prog_driver #(.PROG_DEPTH(PD), .PROG_AW(PAW), .RES_DEPTH(RD), .RES_AW(RAW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .busy(busy), .done(done), .prog_len(prog_len),
    .cpu_ui(cpu_ui), .cpu_uio(cpu_uio), .cpu_uo(cpu_uo), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready));

  // Minimal CPU: LDB(1) r,imm / ADD(B) r1=r2+r3 with carry / STB(2) r1 / RDS(3) carry.
  logic [7:0] cpu_r [16];
  logic       cpu_c;
  logic [7:0] cpu_uo_q;
  assign cpu_uo = cpu_uo_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cpu_r[i] <= 8'h00;
      cpu_c    <= 1'b0;
      cpu_uo_q <= 8'h00;
    end else begin
      case (cpu_ui[7:4])
        4'h1: cpu_r[cpu_ui[3:0]] <= cpu_uio;
        4'hB: {cpu_c, cpu_r[cpu_ui[3:0]]} <= {1'b0, cpu_r[cpu_uio[7:4]]} + {1'b0, cpu_r[cpu_uio[3:0]]};
        4'h2: cpu_uo_q <= cpu_r[cpu_ui[3:0]];
        4'h3: cpu_uo_q <= {7'b0, cpu_c};
        default: ;
      endcase
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: program as a queue, results as a queue, and each issued
  // capture remembered by the edge number at which its result is due.
  logic [15:0] m_prog[$];
  logic [7:0]  m_res[$];
  int          m_due[$];
  int          m_mode = 0, m_idx = 0, edge_n = 0;
  logic [7:0]  e_ui = 8'h40, e_uio = 8'h00, e_resd = 8'h00;
  logic        e_busy = 0, e_done = 0, e_lr = 1, e_resv = 0;
  int          e_len = 0;

  initial begin
    int fc, infl;
    logic [15:0] w;
    bit cap;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_prog.delete(); m_res.delete(); m_due.delete();
        m_mode = 0; m_idx = 0;
        e_ui = 8'h40; e_uio = 8'h00; e_done = 0;
      end else begin
        edge_n++;
        fc = m_res.size(); infl = m_due.size();
        if (res_ready && fc > 0) void'(m_res.pop_front());
        if (infl > 0 && m_due[0] == edge_n) begin
          m_res.push_back(cpu_uo);
          void'(m_due.pop_front());
        end
        e_ui = 8'h40; e_uio = 8'h00; e_done = 0;
        if (m_mode == 0) begin
          if (clear) m_prog.delete();
          else begin
            if (load_valid && m_prog.size() < PD) m_prog.push_back(load_data);
            if (start && m_prog.size() > 0) begin m_mode = 1; m_idx = 0; end
          end
        end else if (m_mode == 1) begin
          w = m_prog[m_idx];
          cap = (w[15:12] == 4'h2) || (w[15:12] == 4'h3);
          if (!cap || fc + infl < RD) begin
            e_ui = w[15:8]; e_uio = w[7:0];
            if (cap) m_due.push_back(edge_n + 2);
            m_idx++;
            if (m_idx == m_prog.size()) m_mode = 2;
          end
        end else if (infl == 0) begin
          e_done = 1; m_mode = 0;
        end
      end
      e_busy = (m_mode != 0);
      e_lr   = (m_mode == 0) && (m_prog.size() < PD);
      e_len  = m_prog.size();
      e_resv = (m_res.size() > 0);
      e_resd = e_resv ? m_res[0] : 8'h00;
    end
  end

  // Compare process plus logs of pins, dones and pops used by literal checks.
  int cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [15:0] pin_log[$];
  int          pin_cyc[$];
  logic [7:0]  pop_log[$];
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("cpu_ui", cpu_ui, e_ui);
      chk("cpu_uio", cpu_uio, e_uio);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("load_ready", load_ready, e_lr);
      chk("prog_len", prog_len, e_len);
      chk("res_valid", res_valid, e_resv);
      if (e_resv) chk("res_data", res_data, e_resd);
      if (cpu_ui != 8'h40 || cpu_uio != 8'h00) begin
        pin_log.push_back({cpu_ui, cpu_uio});
        pin_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (res_valid && res_ready) pop_log.push_back(res_data);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic load(input logic [15:0] w);
    load_valid = 1; load_data = w; tick(); load_valid = 0;
  endtask
  task automatic go(); start = 1; tick(); start = 0; endtask
  task automatic do_clear(); clear = 1; tick(); clear = 0; endtask
  task automatic wait_done(input string nm, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    repeat (4) tick();
    chk({nm, "_one_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] run1[$];
    int n, d0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    tick();
    chk("rst_ui", cpu_ui, 8'h40);
    chk("rst_uio", cpu_uio, 8'h00);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 8'h00);

    // LDB r1,0x5A ; STB r1
    pin_log.delete(); pin_cyc.delete(); pop_log.delete();
    load(16'h115A); load(16'h2100); go();
    wait_done("t1", 30);
    chk("t1_pins_n", pin_log.size(), 2);
    if (pin_log.size() == 2) begin
      chk("t1_pin0", pin_log[0], 16'h115A);
      chk("t1_pin1", pin_log[1], 16'h2100);
      chk("t1_consec", pin_cyc[1] - pin_cyc[0], 1);
      chk("t1_done_lat", done_cyc - pin_cyc[1], 3);
    end
    chk("t1_busy", busy, 0);
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_data", res_data, 8'h5A);
    res_ready = 1; tick(); res_ready = 0;
    chk("t1_popped", res_valid, 0);

    // ADD with carry, then RDS and STB
    do_clear();
    load(16'h12F0); load(16'h1320); load(16'hB123); load(16'h3000); load(16'h2100);
    go();
    wait_done("t2", 40);
    chk("t2_first", res_data, 8'h01);
    res_ready = 1; tick(); res_ready = 0;
    chk("t2_second_valid", res_valid, 1);
    chk("t2_second", res_data, 8'h10);
    res_ready = 1; tick(); res_ready = 0;
    chk("t2_empty", res_valid, 0);

    // Back-pressure: six STBs into a 4-entry FIFO with the consumer stalled
    do_clear();
    pin_log.delete(); pin_cyc.delete(); pop_log.delete();
    load(16'h1133);
    repeat (6) load(16'h2100);
    go();
    repeat (25) tick();
    n = 0;
    foreach (pin_log[i]) if (pin_log[i] == 16'h2100) n++;
    chk("t3_stb_issued", n, 4);
    chk("t3_busy", busy, 1);
    chk("t3_nop_held", {cpu_ui, cpu_uio}, 16'h4000);
    res_ready = 1;
    wait_done("t3", 60);
    res_ready = 0;
    chk("t3_pops", pop_log.size(), 6);
    foreach (pop_log[i]) chk("t3_pop_val", pop_log[i], 8'h33);
    if (pin_cyc.size() > 0) chk("t3_done_after_cap", done_cyc >= pin_cyc[pin_cyc.size()-1] + 3, 1);

    // Fill to capacity, 17th refused, clear, start on empty program
    do_clear();
    for (int i = 0; i < 16; i++) load(16'h1000 + 16'(i));
    chk("t4_len_full", prog_len, 16);
    chk("t4_ready_full", load_ready, 0);
    load(16'h1111);
    chk("t4_len_17th", prog_len, 16);
    do_clear();
    chk("t4_cleared", prog_len, 0);
    clear = 1; load_valid = 1; load_data = 16'h1222; tick(); clear = 0; load_valid = 0;
    chk("t4_clear_prio", prog_len, 0);
    d0 = done_cnt;
    go();
    repeat (5) tick();
    chk("t4_empty_busy", busy, 0);
    chk("t4_empty_done", done_cnt - d0, 0);

    // Reset in the middle of an 8-word run
    pin_log.delete(); pin_cyc.delete();
    load(16'h1101); load(16'h2100); load(16'h1102); load(16'h1103);
    load(16'h1104); load(16'h1105); load(16'h1106); load(16'h1107);
    go();
    for (int i = 0; i < 20 && pin_log.size() < 3; i++) tick();
    chk("t5_reached_word3", pin_log.size() >= 3, 1);
    chk("t5_pre_res_valid", res_valid, 1);
    d0 = done_cnt;
    rst = 1; tick();
    chk("t5_ui", cpu_ui, 8'h40);
    chk("t5_uio", cpu_uio, 8'h00);
    chk("t5_busy", busy, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_prog_len", prog_len, 0);
    rst = 0;
    repeat (6) tick();
    chk("t5_no_done", done_cnt - d0, 0);

    // Replay the same 2-STB program twice; second word loaded with start
    res_ready = 1;
    pin_log.delete(); pin_cyc.delete(); pop_log.delete();
    load(16'h2100);
    load_valid = 1; load_data = 16'h2100; start = 1; tick(); load_valid = 0; start = 0;
    wait_done("t6a", 30);
    run1 = pin_log;
    chk("t6a_pops", pop_log.size(), 2);
    pin_log.delete(); pin_cyc.delete(); pop_log.delete();
    go();
    wait_done("t6b", 30);
    chk("t6b_pops", pop_log.size(), 2);
    chk("t6_len1", run1.size(), 2);
    chk("t6_len2", pin_log.size(), 2);
    if (run1.size() == 2 && pin_log.size() == 2) begin
      chk("t6_w0", pin_log[0], run1[0]);
      chk("t6_w1", pin_log[1], run1[1]);
      chk("t6_w0_lit", run1[0], 16'h2100);
      chk("t6_consec", pin_cyc[1] - pin_cyc[0], 1);
    end
    res_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_prog_driver.md
Name: cpu_prog_driver

Overview:
- Host-side initiator for the 8-bit CPU pin interface.
- Buffers a short program of 16-bit instruction words and replays it onto the CPU instruction pins, one word per cycle.
- Captures the CPU `uo_out` byte after every STB/RDS into a result FIFO with valid/ready back-pressure.
- Sits in the bench/FPGA harness and on-chip test wrappers, between a loader (UART/SPI bridge) and the CPU pins.

Parameters:
- PROG_DEPTH, 16, number of instruction words in program buffer (power of 2).
- PROG_AW, 4, log2(PROG_DEPTH).
- RES_DEPTH, 4, result FIFO entries (power of 2, >=2).
- RES_AW, 2, log2(RES_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  empties program buffer; honoured in IDLE only.
- load_valid  in  1  program word valid.
- load_data  in  16  [15:8] drives cpu_ui, [7:0] drives cpu_uio.
- load_ready  out  1  buffer accepts word.
- start  in  1  begin replay; honoured in IDLE with prog_len>0.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of replay.
- prog_len  out  PROG_AW+1  words currently stored.
- cpu_ui  out  8  to CPU ui_in (opcode[7:4], r1[3:0]).
- cpu_uio  out  8  to CPU uio_in (r2/r3 or immediate).
- cpu_uo  in  8  from CPU uo_out.
- res_valid  out  1  result FIFO non-empty.
- res_data  out  8  FIFO head.
- res_ready  in  1  consumer pops head when res_valid&res_ready.

Behaviour:
- Reset values:
  - cpu_ui=8'h40 (NOP opcode 0100), cpu_uio=8'h00.
  - load_ready=1, busy=0, done=0, prog_len=0, res_valid=0, res_data=0.
  - State IDLE; all pointers and counters 0; capture pipeline cleared.
- cpu_ui/cpu_uio are registered. Outside of an issuing cycle they hold NOP (8'h40/8'h00).
- States: IDLE, RUN, DRAIN.
- IDLE:
  - load_ready = (prog_len < PROG_DEPTH).
  - load_valid&load_ready writes the word at index prog_len, then prog_len++. Words offered while full are not accepted and not written.
  - clear sets prog_len=0 and takes priority over a same-cycle load.
  - start with prog_len>0 moves to RUN with rd_ptr=0. start with prog_len==0 is ignored: no busy, no done.
  - start and load in the same cycle: the load is accepted first, and the new word is included in the replay.
- RUN:
  - load_ready=0; start, clear and load_valid are ignored.
  - Each cycle the word at rd_ptr is a candidate.
  - Capture-type words are opcode 0010 (STB) and 0011 (RDS).
  - A capture-type word issues only if fifo_count + inflight < RES_DEPTH. Otherwise it stalls: NOP is driven and rd_ptr holds. Non-capture words never stall.
  - An issued word drives cpu_ui/cpu_uio for exactly one cycle; rd_ptr++.
  - After issuing word prog_len-1, next state is DRAIN.
- Capture timing:
  - A word presented on the pins in cycle N is sampled by the CPU at the edge ending N.
  - For capture-type words, cpu_uo is sampled at the edge ending cycle N+1 and pushed into the FIFO.
  - This is a 2-stage tag pipeline; inflight = number of set tags (0..2).
- DRAIN: NOP driven. When inflight==0, pulse done for 1 cycle and return to IDLE. The program is retained; start replays it.
- Result FIFO:
  - Push and pop in the same cycle are both allowed; fifo_count is unchanged.
  - The stall rule guarantees no push while full, so no overflow path exists.
  - Results persist across done and across later starts until popped.
  - Pop while empty has no effect.
- Back-to-back STB words issue on consecutive cycles when FIFO room allows (throughput 1 word/cycle).
- Reset mid-operation: everything returns to reset values immediately (async).
  - Program buffer contents need not be cleared; prog_len=0 makes them unreachable.
  - No done pulse is produced.

Test Plan:
- Load 0x115A (LDB r1,0x5A) and 0x2100 (STB r1), then start. Required:
  - pins show 0x11/0x5A then 0x21/0x00 on consecutive cycles;
  - res_data=0x5A valid;
  - done pulses 3 cycles after the last issue cycle;
  - busy falls with done.
- Program 0x12F0, 0x1320, 0xB123 (ADD r1=r2+r3), 0x3000 (RDS), 0x2100. Required: results 0x01 then 0x10 in order (CPU model in bench).
- Back-pressure: res_ready=0 with 6 × 0x2100 after LDB r1,0x33. Required:
  - exactly 4 STBs issue, then NOP held;
  - raising res_ready drains six 0x33 results in order;
  - done only after the last capture.
- Load 17 words. Required: the 17th word is refused (load_ready=0 at prog_len=16). clear then reports prog_len=0. start with prog_len=0 gives no busy/done.
- Assert rst during RUN at word 3 of 8. Required: next cycle pins show 0x40/0x00, busy=0, res_valid=0, prog_len=0, no done.
- Replay: start twice on the same 2-word STB program with res_ready=1. Required: identical pin sequences, two results per run, one done per run.
